sseg_display_ctrl: RTL

//  N-digit multiplexed seven-segment display controller. It captures a binary value and converts it to BCD

---
 rtl/sseg_display_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/sseg_display_ctrl.sv
// Multiplexed N-digit seven-segment controller: double-dabble binary->BCD, digit scan, blink, LZ blanking.
// Latency: busy for NUM_WIDTH clks after load; an/cat registered one clk after the digit select moves.
// Backpressure: none; load is ignored while busy, and the display keeps the last completed value.
module sseg_display_ctrl #(
    parameter int NUM_DIGITS  = 4,
    parameter int NUM_WIDTH   = 14,
    parameter int REFRESH_DIV = 20000,
    parameter int BLINK_DIV   = 250,
    parameter int AN_ACT_LOW  = 1,
    parameter int CAT_ACT_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [NUM_WIDTH-1:0]  num,
    input  logic [NUM_DIGITS-1:0] dig_en,
    input  logic [NUM_DIGITS-1:0] dp_en,
    input  logic [NUM_DIGITS-1:0] blink_en,
    input  logic                  lz_blank,
    output logic                  busy,
    output logic                  overflow,
    output logic [NUM_DIGITS-1:0] an,
    output logic [7:0]            cat
);

    // Work register must hold every decimal digit of the widest input, plus at least one guard nibble.
    localparam int BCD_DIG = (NUM_DIGITS + 1 > (NUM_WIDTH + 2) / 3) ? NUM_DIGITS + 1 : (NUM_WIDTH + 2) / 3;
    localparam int BCD_W   = 4 * BCD_DIG;
    localparam int SHD_W   = 4 * NUM_DIGITS;
    localparam int CNT_W   = (NUM_WIDTH > 1) ? $clog2(NUM_WIDTH) : 1;
    localparam int REF_W   = $clog2(REFRESH_DIV);
    localparam int BLK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int SEL_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic AN_INV  = (AN_ACT_LOW != 0);
    localparam logic CAT_INV = (CAT_ACT_LOW != 0);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_CONV = 1'b1;

    logic [0:0]            state;
    logic [CNT_W-1:0]      conv_cnt;
    logic [NUM_WIDTH-1:0]  bin_reg, bin_nxt;
    logic [BCD_W-1:0]      bcd_reg, bcd_adj, bcd_nxt;
    logic [SHD_W-1:0]      shadow;

    logic [REF_W-1:0]      ref_cnt;
    logic                  tick;
    logic [SEL_W-1:0]      dig_sel;
    logic [BLK_W-1:0]      blk_cnt;
    logic                  blink_ph;

    logic [3:0]            nib;
    logic                  upper_zero, sel_en, sel_dp, sel_blink, lz_hit, lit;
    logic [6:0]            glyph;
    logic [NUM_DIGITS-1:0] an_int;
    logic [7:0]            cat_int;

    assign busy = (state == S_CONV);
    assign tick = (ref_cnt == REF_W'(REFRESH_DIV - 1));

    always_comb begin
        bcd_adj = bcd_reg;
        for (int k = 0; k < BCD_DIG; k++) begin
            if (bcd_adj[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd_adj[4*k +: 4] + 4'd3;
            end
        end
        bcd_nxt = {bcd_adj[BCD_W-2:0], bin_reg[NUM_WIDTH-1]};
        bin_nxt = bin_reg << 1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            conv_cnt <= '0;
            bin_reg  <= '0;
            bcd_reg  <= '0;
            shadow   <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (load) begin
                        bin_reg  <= num;
                        bcd_reg  <= '0;
                        conv_cnt <= '0;
                        state    <= S_CONV;
                    end
                end
                default: begin
                    bin_reg <= bin_nxt;
                    bcd_reg <= bcd_nxt;
                    if (conv_cnt == CNT_W'(NUM_WIDTH - 1)) begin
                        shadow   <= bcd_nxt[SHD_W-1:0];
                        overflow <= |bcd_nxt[BCD_W-1:SHD_W];
                        state    <= S_IDLE;
                    end else begin
                        conv_cnt <= conv_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ref_cnt  <= '0;
            dig_sel  <= '0;
            blk_cnt  <= '0;
            blink_ph <= 1'b0;
        end else if (tick) begin
            ref_cnt <= '0;
            dig_sel <= (dig_sel == SEL_W'(NUM_DIGITS - 1)) ? '0 : dig_sel + 1'b1;
            if (blk_cnt == BLK_W'(BLINK_DIV - 1)) begin
                blk_cnt  <= '0;
                blink_ph <= ~blink_ph;
            end else begin
                blk_cnt <= blk_cnt + 1'b1;
            end
        end else begin
            ref_cnt <= ref_cnt + 1'b1;
        end
    end

    // Digit mux plus a scan of the selected nibble and everything above it for blanking.
    always_comb begin
        nib        = 4'd0;
        upper_zero = 1'b1;
        sel_en     = 1'b0;
        sel_dp     = 1'b0;
        sel_blink  = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (SEL_W'(k) == dig_sel) begin
                nib       = shadow[4*k +: 4];
                sel_en    = dig_en[k];
                sel_dp    = dp_en[k];
                sel_blink = blink_en[k];
            end
            if (k >= int'(dig_sel) && shadow[4*k +: 4] != 4'd0) begin
                upper_zero = 1'b0;
            end
        end
        lz_hit = lz_blank && (dig_sel != '0) && !overflow && upper_zero;
        lit    = sel_en && !(sel_blink && blink_ph) && !lz_hit;
        case (nib)
            4'd0:    glyph = 7'h3F;
            4'd1:    glyph = 7'h06;
            4'd2:    glyph = 7'h5B;
            4'd3:    glyph = 7'h4F;
            4'd4:    glyph = 7'h66;
            4'd5:    glyph = 7'h6D;
            4'd6:    glyph = 7'h7D;
            4'd7:    glyph = 7'h07;
            4'd8:    glyph = 7'h7F;
            4'd9:    glyph = 7'h6F;
            4'd10:   glyph = 7'h77;
            4'd11:   glyph = 7'h7C;
            4'd12:   glyph = 7'h39;
            4'd13:   glyph = 7'h5E;
            4'd14:   glyph = 7'h79;
            default: glyph = 7'h71;
        endcase
        if (overflow) begin
            glyph = 7'h40;
        end
        an_int  = lit ? (NUM_DIGITS'(1) << dig_sel) : '0;
        cat_int = lit ? {sel_dp, glyph} : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= {NUM_DIGITS{AN_INV}};
            cat <= {8{CAT_INV}};
        end else begin
            an  <= an_int ^ {NUM_DIGITS{AN_INV}};
            cat <= cat_int ^ {8{CAT_INV}};
        end
    end

endmodule
